// File: rtl/cpm_fifo_mc_if.sv
// Handshake and status bundle for the multi-channel FIFO.
// Channel c occupies slice c of every vector.
interface cpm_fifo_mc_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CH     = 2
);
    logic [NUM_CH-1:0]                  ch_clr;
    logic [NUM_CH-1:0]                  push;
    logic [NUM_CH-1:0]                  pop;
    logic [NUM_CH*DATA_WIDTH-1:0]       data_in;
    logic [NUM_CH*DATA_WIDTH-1:0]       data_out;
    logic [NUM_CH-1:0]                  empty;
    logic [NUM_CH-1:0]                  full;
    logic [NUM_CH-1:0]                  almost_empty;
    logic [NUM_CH-1:0]                  almost_full;
    logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   fifo_count;
    logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   fifo_count_empty;
    logic [NUM_CH-1:0]                  overflow;
    logic [NUM_CH-1:0]                  underflow;

    modport master (
        output ch_clr, push, pop, data_in,
        input  data_out, empty, full, almost_empty, almost_full,
        input  fifo_count, fifo_count_empty, overflow, underflow
    );

    modport slave (
        input  ch_clr, push, pop, data_in,
        output data_out, empty, full, almost_empty, almost_full,
        output fifo_count, fifo_count_empty, overflow, underflow
    );
endinterface

// File: rtl/cpm_fifo_mc.sv
// NUM_CH independent synchronous FIFOs sharing one clock, with per-channel
// status flags, sticky error flags and optional registered read data.
module cpm_fifo_mc #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CH     = 2,
    parameter int REG_OUT    = 0,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Reset,
    cpm_fifo_mc_if.slave  bus
);
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW        = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    function automatic logic at_or_above(input logic [CW-1:0] cnt, input int lvl);
        return int'(cnt) >= lvl;
    endfunction

    function automatic logic at_or_below(input logic [CW-1:0] cnt, input int lvl);
        return int'(cnt) <= lvl;
    endfunction

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] dout_s;
    logic [NUM_CH-1:0][CW-1:0]         count_s;
    logic [NUM_CH-1:0][CW-1:0]         free_s;
    logic [NUM_CH-1:0]                 empty_s;
    logic [NUM_CH-1:0]                 full_s;
    logic [NUM_CH-1:0]                 ae_s;
    logic [NUM_CH-1:0]                 af_s;
    logic [NUM_CH-1:0]                 ovf_s;
    logic [NUM_CH-1:0]                 udf_s;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];
        logic [ADDR_WIDTH-1:0] wr_ptr_r;
        logic [ADDR_WIDTH-1:0] rd_ptr_r;
        logic [CW-1:0]         count_r;
        logic [CW-1:0]         free_r;
        logic [CW-1:0]         count_next_s;
        logic                  empty_r;
        logic                  full_r;
        logic                  ae_r;
        logic                  af_r;
        logic                  ovf_r;
        logic                  udf_r;
        logic                  clr_s;
        logic                  push_ok_s;
        logic                  pop_ok_s;
        logic [DATA_WIDTH-1:0] din_s;
        logic [DATA_WIDTH-1:0] head_s;

        assign din_s  = bus.data_in[c*DATA_WIDTH +: DATA_WIDTH];
        assign head_s = mem_r[rd_ptr_r];

        // Accept decode; a pop frees the slot a full-FIFO push needs.
        always_comb begin
            clr_s        = Reset | bus.ch_clr[c];
            push_ok_s    = bus.push[c] & (~full_r | bus.pop[c]);
            pop_ok_s     = bus.pop[c] & ~empty_r;
            count_next_s = count_r;
            if (clr_s) begin
                count_next_s = ZERO_C;
            end else if (push_ok_s && !pop_ok_s) begin
                count_next_s = count_r + CW'(1);
            end else if (pop_ok_s && !push_ok_s) begin
                count_next_s = count_r - CW'(1);
            end else begin
                count_next_s = count_r;
            end
        end

        // Pointers, count, status flags (pre-decoded from next count) and error flags.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_r <= {ADDR_WIDTH{1'b0}};
                rd_ptr_r <= {ADDR_WIDTH{1'b0}};
                count_r  <= ZERO_C;
                free_r   <= DEPTH_C;
                empty_r  <= 1'b1;
                full_r   <= 1'b0;
                ae_r     <= 1'b1;
                af_r     <= 1'b0;
                ovf_r    <= 1'b0;
                udf_r    <= 1'b0;
            end else begin
                count_r <= count_next_s;
                free_r  <= DEPTH_C - count_next_s;
                empty_r <= (count_next_s == ZERO_C);
                full_r  <= (count_next_s == DEPTH_C);
                ae_r    <= at_or_below(count_next_s, AE_LEVEL);
                af_r    <= at_or_above(count_next_s, AF_LEVEL);
                if (clr_s) begin
                    wr_ptr_r <= {ADDR_WIDTH{1'b0}};
                    rd_ptr_r <= {ADDR_WIDTH{1'b0}};
                    ovf_r    <= 1'b0;
                    udf_r    <= 1'b0;
                end else begin
                    if (push_ok_s) wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
                    if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
                    if (bus.push[c] && !push_ok_s) ovf_r <= 1'b1;
                    if (bus.pop[c] && !pop_ok_s)   udf_r <= 1'b1;
                end
            end
        end

        // Storage; only the power-on reset wipes it, a clear leaves contents stale.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < RAM_DEPTH; i++) mem_r[i] <= {DATA_WIDTH{1'b0}};
            end else if (push_ok_s && !clr_s) begin
                mem_r[wr_ptr_r] <= din_s;
            end
        end

        if (REG_OUT != 0) begin : g_reg_out
            logic [DATA_WIDTH-1:0] dout_r;

            // Capture the head word as it is popped.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_r <= {DATA_WIDTH{1'b0}};
                end else if (pop_ok_s && !clr_s) begin
                    dout_r <= head_s;
                end
            end
            assign dout_s[c] = dout_r;
        end else begin : g_comb_out
            assign dout_s[c] = head_s;
        end

        assign count_s[c] = count_r;
        assign free_s[c]  = free_r;
        assign empty_s[c] = empty_r;
        assign full_s[c]  = full_r;
        assign ae_s[c]    = ae_r;
        assign af_s[c]    = af_r;
        assign ovf_s[c]   = ovf_r;
        assign udf_s[c]   = udf_r;
    end

    assign bus.data_out         = dout_s;
    assign bus.fifo_count       = count_s;
    assign bus.fifo_count_empty = free_s;
    assign bus.empty            = empty_s;
    assign bus.full             = full_s;
    assign bus.almost_empty     = ae_s;
    assign bus.almost_full      = af_s;
    assign bus.overflow         = ovf_s;
    assign bus.underflow        = udf_s;
endmodule

// File: tb/tb_cpm_fifo_mc.sv
// Randomized and directed bench for cpm_fifo_mc: one combinational-read and one
// registered-read instance driven identically, checked against a queue model.
module tb_cpm_fifo_mc;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NC = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic reset_v;
    logic [NC-1:0]    push_v;
    logic [NC-1:0]    pop_v;
    logic [NC-1:0]    clr_v;
    logic [NC*DW-1:0] din_v;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq [NC][$];
    logic [DW-1:0] dreg [NC];
    logic          ov_m [NC];
    logic          un_m [NC];

    always #5 clk = ~clk;

    cpm_fifo_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) bus0 ();
    cpm_fifo_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) bus1 ();

    assign bus0.push = push_v;   assign bus1.push = push_v;
    assign bus0.pop = pop_v;     assign bus1.pop = pop_v;
    assign bus0.ch_clr = clr_v;  assign bus1.ch_clr = clr_v;
    assign bus0.data_in = din_v; assign bus1.data_in = din_v;

    cpm_fifo_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .REG_OUT(0),
                  .AF_LEVEL(3), .AE_LEVEL(1))
        dut0 (.clk(clk), .rst_n(rst_n), .Reset(reset_v), .bus(bus0));

    cpm_fifo_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .REG_OUT(1),
                  .AF_LEVEL(3), .AE_LEVEL(1))
        dut1 (.clk(clk), .rst_n(rst_n), .Reset(reset_v), .bus(bus1));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear_all();
        for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            dreg[c] = '0;
            ov_m[c] = 1'b0;
            un_m[c] = 1'b0;
        end
    endtask

    // Applies one clock edge worth of the FIFO rules to the queues.
    task automatic model_step();
        for (int c = 0; c < NC; c++) begin
            int sz;
            bit pop_acc;
            bit push_acc;
            sz       = mq[c].size();
            pop_acc  = pop_v[c] && (sz > 0);
            push_acc = push_v[c] && ((sz < DEPTH) || pop_v[c]);
            if (reset_v || clr_v[c]) begin
                mq[c].delete();
                ov_m[c] = 1'b0;
                un_m[c] = 1'b0;
            end else begin
                if (push_v[c] && !push_acc) ov_m[c] = 1'b1;
                if (pop_v[c] && !pop_acc)   un_m[c] = 1'b1;
                if (pop_acc)  dreg[c] = mq[c].pop_front();
                if (push_acc) mq[c].push_back(din_v[c*DW +: DW]);
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                int sz;
                logic [AW:0] cnt, fr;
                logic e, f, ae, af, ov, un;
                logic [DW-1:0] dout;
                sz = mq[c].size();
                if (d == 0) begin
                    cnt = bus0.fifo_count[c*(AW+1) +: (AW+1)];
                    fr  = bus0.fifo_count_empty[c*(AW+1) +: (AW+1)];
                    e = bus0.empty[c]; f = bus0.full[c];
                    ae = bus0.almost_empty[c]; af = bus0.almost_full[c];
                    ov = bus0.overflow[c]; un = bus0.underflow[c];
                    dout = bus0.data_out[c*DW +: DW];
                end else begin
                    cnt = bus1.fifo_count[c*(AW+1) +: (AW+1)];
                    fr  = bus1.fifo_count_empty[c*(AW+1) +: (AW+1)];
                    e = bus1.empty[c]; f = bus1.full[c];
                    ae = bus1.almost_empty[c]; af = bus1.almost_full[c];
                    ov = bus1.overflow[c]; un = bus1.underflow[c];
                    dout = bus1.data_out[c*DW +: DW];
                end
                check_eq($sformatf("d%0d_c%0d_count", d, c), 32'(cnt), 32'(sz));
                check_eq($sformatf("d%0d_c%0d_free", d, c), 32'(fr), 32'(DEPTH - sz));
                check_eq($sformatf("d%0d_c%0d_empty", d, c), 32'(e), 32'(sz == 0));
                check_eq($sformatf("d%0d_c%0d_full", d, c), 32'(f), 32'(sz == DEPTH));
                check_eq($sformatf("d%0d_c%0d_aempty", d, c), 32'(ae), 32'(sz <= 1));
                check_eq($sformatf("d%0d_c%0d_afull", d, c), 32'(af), 32'(sz >= 3));
                check_eq($sformatf("d%0d_c%0d_ovf", d, c), 32'(ov), 32'(ov_m[c]));
                check_eq($sformatf("d%0d_c%0d_udf", d, c), 32'(un), 32'(un_m[c]));
                if (d == 0 && sz > 0)
                    check_eq($sformatf("d0_c%0d_head", c), 32'(dout), 32'(mq[c][0]));
                if (d == 1)
                    check_eq($sformatf("d1_c%0d_dreg", c), 32'(dout), 32'(dreg[c]));
            end
        end
    endtask

    // Called at a falling edge: drive, model, clock once, return to falling edge and check.
    task automatic cyc(input logic [1:0] p, input logic [1:0] q, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] cl, input logic rs);
        push_v = p; pop_v = q; din_v = {d1, d0}; clr_v = cl; reset_v = rs;
        model_step();
        @(posedge clk);
        @(negedge clk);
        push_v = '0; pop_v = '0; clr_v = '0; reset_v = 1'b0;
        check_all();
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic [1:0] p, q, cl;
            logic rs;
            p  = 2'($urandom_range(0, 3));
            q  = 2'($urandom_range(0, 3));
            cl = {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)};
            rs = ($urandom_range(0, 59) == 0);
            cyc(p, q, 8'($urandom), 8'($urandom), cl, rs);
        end
    endtask

    logic [7:0] exp_drain [4];

    initial begin
        exp_drain = '{8'h22, 8'h33, 8'h44, 8'h55};
        rst_n = 1'b0; reset_v = 1'b0;
        push_v = '0; pop_v = '0; clr_v = '0; din_v = '0;
        model_clear_all();
        repeat (2) @(negedge clk);
        check_all();
        check_eq("rst_dout0", 32'(bus0.data_out), 32'h0);
        check_eq("rst_dout1", 32'(bus1.data_out), 32'h0);
        rst_n = 1'b1;

        // Fill channel 0.
        cyc(2'b01, 2'b00, 8'h11, 8'h00, 2'b00, 1'b0);
        cyc(2'b01, 2'b00, 8'h22, 8'h00, 2'b00, 1'b0);
        cyc(2'b01, 2'b00, 8'h33, 8'h00, 2'b00, 1'b0);
        cyc(2'b01, 2'b00, 8'h44, 8'h00, 2'b00, 1'b0);
        check_eq("fill_full0", 32'(bus0.full[0]), 32'h1);
        check_eq("fill_count0", 32'(bus0.fifo_count[2:0]), 32'h4);
        check_eq("fill_free0", 32'(bus0.fifo_count_empty[2:0]), 32'h0);
        check_eq("fill_af0", 32'(bus0.almost_full[0]), 32'h1);
        check_eq("fill_ch1_empty", 32'(bus0.empty[1]), 32'h1);

        // Push and pop together while full.
        cyc(2'b01, 2'b01, 8'h55, 8'h00, 2'b00, 1'b0);
        check_eq("fullpp_count0", 32'(bus0.fifo_count[2:0]), 32'h4);
        check_eq("fullpp_ovf0", 32'(bus0.overflow[0]), 32'h0);
        check_eq("fullpp_dreg0", 32'(bus1.data_out[7:0]), 32'h11);

        cyc(2'b01, 2'b00, 8'h66, 8'h00, 2'b00, 1'b0);
        check_eq("ovf_set0", 32'(bus0.overflow[0]), 32'h1);
        check_eq("ovf_count0", 32'(bus0.fifo_count[2:0]), 32'h4);

        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain_head%0d", i), 32'(bus0.data_out[7:0]), 32'(exp_drain[i]));
            cyc(2'b00, 2'b01, 8'h00, 8'h00, 2'b00, 1'b0);
            check_eq($sformatf("drain_reg%0d", i), 32'(bus1.data_out[7:0]), 32'(exp_drain[i]));
        end

        // Push and pop together on empty channel 1.
        cyc(2'b10, 2'b10, 8'h00, 8'hA5, 2'b00, 1'b0);
        check_eq("emptypp_count1", 32'(bus0.fifo_count[5:3]), 32'h1);
        check_eq("emptypp_udf1", 32'(bus0.underflow[1]), 32'h1);
        check_eq("emptypp_head1", 32'(bus0.data_out[15:8]), 32'hA5);

        // Registered read latency and hold.
        cyc(2'b01, 2'b00, 8'h5A, 8'h00, 2'b00, 1'b0);
        check_eq("regout_before_pop", 32'(bus1.data_out[7:0]), 32'h55);
        cyc(2'b00, 2'b01, 8'h00, 8'h00, 2'b00, 1'b0);
        check_eq("regout_after_pop", 32'(bus1.data_out[7:0]), 32'h5A);
        cyc(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
        check_eq("regout_hold", 32'(bus1.data_out[7:0]), 32'h5A);

        // Channel clear beats a same-cycle push.
        cyc(2'b01, 2'b00, 8'h01, 8'h00, 2'b00, 1'b0);
        cyc(2'b01, 2'b00, 8'h02, 8'h00, 2'b00, 1'b0);
        cyc(2'b01, 2'b00, 8'h03, 8'h00, 2'b00, 1'b0);
        check_eq("preclr_count0", 32'(bus0.fifo_count[2:0]), 32'h3);
        cyc(2'b01, 2'b00, 8'h04, 8'h00, 2'b01, 1'b0);
        check_eq("clr_count0", 32'(bus0.fifo_count[2:0]), 32'h0);
        check_eq("clr_empty0", 32'(bus0.empty[0]), 32'h1);
        check_eq("clr_ovf0", 32'(bus0.overflow[0]), 32'h0);
        check_eq("clr_udf0", 32'(bus0.underflow[0]), 32'h0);
        check_eq("clr_ch1_count", 32'(bus0.fifo_count[5:3]), 32'h1);
        check_eq("clr_ch1_udf", 32'(bus0.underflow[1]), 32'h1);

        random_cycles(400);

        // Asynchronous reset mid-stream, checked before any clock edge.
        cyc(2'b11, 2'b00, 8'h77, 8'h88, 2'b00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_count", 32'(bus0.fifo_count), 32'h0);
        check_eq("arst_free", 32'(bus0.fifo_count_empty), 32'h24);
        check_eq("arst_empty", 32'(bus0.empty), 32'h3);
        check_eq("arst_aempty", 32'(bus1.almost_empty), 32'h3);
        check_eq("arst_full", 32'(bus0.full), 32'h0);
        check_eq("arst_afull", 32'(bus1.almost_full), 32'h0);
        check_eq("arst_ovf", 32'({bus0.overflow, bus1.overflow}), 32'h0);
        check_eq("arst_udf", 32'({bus0.underflow, bus1.underflow}), 32'h0);
        check_eq("arst_dout0", 32'(bus0.data_out), 32'h0);
        check_eq("arst_dout1", 32'(bus1.data_out), 32'h0);
        model_clear_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        random_cycles(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpm_fifo_mc.md
CPM_FIFO_MC -- requirements
Module: cpm_fifo_mc

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DATA_WIDTH, 64, word width per channel.
- ADDR_WIDTH, 4, pointer width; RAM_DEPTH = 2^ADDR_WIDTH words per channel.
- NUM_CH, 2, number of independent FIFO channels (1..8).
- REG_OUT, 0, 0 = combinational read of head word; 1 = registered read.
- AF_LEVEL, RAM_DEPTH-2, almost-full threshold (count >= AF_LEVEL).
- AE_LEVEL, 2, almost-empty threshold (count <= AE_LEVEL).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning. Channel c occupies slice c of every vector.
- clk, in, 1, sole clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- Reset, in, 1, synchronous clear of all channels.
- ch_clr, in, NUM_CH, synchronous clear per channel.
- push, in, NUM_CH, write request.
- pop, in, NUM_CH, read request.
- data_in, in, NUM_CH*DATA_WIDTH, write data.
- data_out, out, NUM_CH*DATA_WIDTH, read data.
- empty, full, almost_empty, almost_full, out, NUM_CH each, status flags.
- fifo_count, out, NUM_CH*(ADDR_WIDTH+1), stored words.
- fifo_count_empty, out, NUM_CH*(ADDR_WIDTH+1), free words.
- overflow, underflow, out, NUM_CH each, sticky error flags.

Function
REQ-003 Each channel SHALL own separate storage, wr/rd pointers and a count; channels SHALL NOT interact.
REQ-004 A push SHALL be accepted when push[c] && (!full[c] || pop[c]); an accepted push writes data_in slice c at wr_ptr and increments wr_ptr modulo RAM_DEPTH.
REQ-005 A pop SHALL be accepted when pop[c] && !empty[c]; an accepted pop increments rd_ptr modulo RAM_DEPTH.
REQ-006 fifo_count SHALL change by +1 on a push-only accept, by -1 on a pop-only accept, and by 0 when both are accepted or neither is.
REQ-007 full + push + pop SHALL accept both operations with the count held at RAM_DEPTH; empty + push + pop SHALL accept the push only, giving count 1.
REQ-008 fifo_count_empty SHALL always equal RAM_DEPTH - fifo_count.
REQ-009 The flags SHALL be decoded from the registered count with zero latency: empty = (count==0), full = (count==RAM_DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-010 overflow[c] SHALL set on a rejected push (push while full without pop), and underflow[c] SHALL set on a rejected pop (pop while empty); both stay set until Reset, ch_clr[c] or rst_n.
REQ-011 With REG_OUT=0, data_out slice c SHALL equal mem[rd_ptr] combinationally; it is valid when !empty.
REQ-012 With REG_OUT=1, data_out slice c SHALL load mem[rd_ptr] on the clock edge of an accepted pop, hold otherwise, and give a one-cycle read latency.
REQ-013 Pointer wrap SHALL be silent; count range SHALL be 0..RAM_DEPTH inclusive.

Reset
REQ-014 rst_n low SHALL asynchronously zero pointers, counts, flags and data_out, zero memory, set fifo_count_empty=RAM_DEPTH, and set empty=1 and almost_empty=1.
REQ-015 Reset (all channels) or ch_clr[c] (channel c) SHALL, on the next edge, zero pointers, count and error flags and set fifo_count_empty=RAM_DEPTH; memory and data_out are not cleared. Clear SHALL take priority over a same-cycle push or pop.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, NUM_CH=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-016 Ch0: push 0x11,0x22,0x33,0x44 -> full[0]=1, count=4, free=0, almost_full=1; 5th push -> overflow[0]=1, count=4; ch1 remains empty=1.
REQ-017 Full ch0 with push 0x55 + pop in the same cycle -> count stays 4, no overflow; drain yields 0x22,0x33,0x44,0x55 (wrap verified).
REQ-018 Empty ch1 with push 0xA5 + pop in the same cycle -> count=1, underflow[1]=1, next data_out[1]=0xA5 (REG_OUT=0).
REQ-019 REG_OUT=1: push 0x5A, pop -> data_out=0x5A one cycle after the pop edge, held while no further pop.
REQ-020 ch_clr[0] asserted with ch0 at count 3 and a same-cycle push -> count=0, empty=1, overflow/underflow=0; ch1 state unchanged.
REQ-021 rst_n pulsed low mid-stream -> all outputs reach reset values immediately, without waiting for a clock edge.
